// File: rtl/led_ring_ctrl.sv
// led_ring_ctrl: two-button run/direction controller for the 2-bit LED ring.
// Buttons are synchronised and debounced, then their press events drive an
// IDLE/FWD/REV state machine. A divided step tick advances the LED code
// forward (decrement) or in reverse (increment). Everything runs on clk.
module led_ring_ctrl #(
  parameter int TICK_DIV  = 13500000,
  parameter int DB_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p1,
  input  logic       p2,
  output logic [1:0] Led,
  output logic       run,
  output logic       dir,
  output logic       tick
);

  localparam int TW = (TICK_DIV  > 2) ? $clog2(TICK_DIV)  : 1;
  localparam int DW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

  // Bit 0 is button 1 (forward), bit 1 is button 2 (reverse).
  logic [1:0] pin;
  logic [1:0] s1_q, s1_d;
  logic [1:0] s2_q, s2_d;
  logic [1:0] db_q, db_d;
  logic [1:0] dbd_q, dbd_d;
  // sv_q marks which synchroniser stages hold a real pin sample rather than
  // the reset value; arm_q is set once a button has been seen released.
  // This keeps a button that is held through reset from firing on release
  // of reset: it must be let go and pressed again.
  logic [1:0] sv_q, sv_d;
  logic [1:0] arm_q, arm_d;
  logic [DW-1:0] dbc_q [2];
  logic [DW-1:0] dbc_d [2];
  logic [1:0] ev;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [1:0]    led_q, led_d;
  logic          run_q, run_d;
  logic          dir_q, dir_d;

  assign pin = {p2, p1};

  // Synchronise, debounce and arm each button.
  always_comb begin
    s1_d  = pin;
    s2_d  = s1_q;
    dbd_d = db_q;
    db_d  = db_q;
    sv_d  = {sv_q[0], 1'b1};
    arm_d = arm_q | ({2{sv_q[1]}} & s2_q);
    for (int i = 0; i < 2; i++) begin
      dbc_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (dbc_q[i] == DB_LAST) begin
          db_d[i] = s2_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + DW'(1);
        end
      end
    end
  end

  // One-cycle press event on the falling edge of the debounced level.
  assign ev = arm_q & dbd_q & ~db_q;

  // Next state from press events; simultaneous presses always pause.
  always_comb begin
    state_d = state_q;
    if (ev == 2'b11) begin
      state_d = IDLE;
    end else if (ev[0]) begin
      state_d = (state_q == FWD) ? IDLE : FWD;
    end else if (ev[1]) begin
      state_d = (state_q == REV) ? IDLE : REV;
    end
    run_d = (state_d != IDLE);
    dir_d = dir_q;
    if (state_d == FWD) begin
      dir_d = 1'b0;
    end else if (state_d == REV) begin
      dir_d = 1'b1;
    end
  end

  assign tick = run_q & (cnt_q == TICK_LAST);

  // Step counter and LED code; a state change clears the count and holds Led.
  always_comb begin
    cnt_d = cnt_q;
    led_d = led_q;
    if (state_d != state_q || state_q == IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = (cnt_q == TICK_LAST) ? '0 : cnt_q + TW'(1);
      if (tick) begin
        led_d = (state_q == REV) ? led_q + 2'd1 : led_q - 2'd1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q    <= 2'b11;
      s2_q    <= 2'b11;
      db_q    <= 2'b11;
      dbd_q   <= 2'b11;
      sv_q    <= 2'b00;
      arm_q   <= 2'b00;
      dbc_q[0] <= '0;
      dbc_q[1] <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      led_q   <= 2'b11;
      run_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      db_q    <= db_d;
      dbd_q   <= dbd_d;
      sv_q    <= sv_d;
      arm_q   <= arm_d;
      dbc_q[0] <= dbc_d[0];
      dbc_q[1] <= dbc_d[1];
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      run_q   <= run_d;
      dir_q   <= dir_d;
    end
  end

  assign Led = led_q;
  assign run = run_q;
  assign dir = dir_q;

endmodule

// File: tb/tb_led_ring_ctrl.sv
// tb_led_ring_ctrl: directed scenarios plus randomized button activity for
// led_ring_ctrl, checked every cycle against a behavioural model.
module tb_led_ring_ctrl;
  localparam int TD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       p1 = 1'b1;
  logic       p2 = 1'b1;
  logic [1:0] Led;
  logic       run, dir, tick;

  int checks = 0;
  int errors = 0;

  led_ring_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .p1(p1), .p2(p2),
    .Led(Led), .run(run), .dir(dir), .tick(tick)
  );

  always #5 clk = ~clk;

  // Behavioural model: pin history, "how long has the synced level disagreed
  // with the accepted level", mode (0 idle, 1 forward, 2 reverse), step phase.
  int m_s1 [2], m_s2 [2], m_db [2], m_dbq [2], m_run_len [2], m_arm [2];
  int m_age = 0, m_mode = 0, m_dir = 0, m_phase = 0, m_led = 3;
  bit m_ok = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int pin [2];
    int ev [2];
    int nmode;
    bit tk;
    pin[0] = p1;
    pin[1] = p2;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 1; m_s2[i] = 1; m_db[i] = 1; m_dbq[i] = 1;
        m_run_len[i] = 0; m_arm[i] = 0;
      end
      m_age = 0; m_mode = 0; m_dir = 0; m_phase = 0; m_led = 3;
      m_ok = 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) ev[i] = (m_arm[i] != 0 && m_dbq[i] == 1 && m_db[i] == 0) ? 1 : 0;
      tk = (m_mode != 0) && (m_phase == TD - 1);
      nmode = m_mode;
      if (ev[0] == 1 && ev[1] == 1) nmode = 0;
      else if (ev[0] == 1) nmode = (m_mode == 1) ? 0 : 1;
      else if (ev[1] == 1) nmode = (m_mode == 2) ? 0 : 2;
      if (nmode != m_mode || m_mode == 0) begin
        m_phase = 0;
      end else begin
        if (tk) m_led = (m_mode == 1) ? (m_led + 3) % 4 : (m_led + 1) % 4;
        m_phase = (m_phase + 1) % TD;
      end
      if (nmode == 1) m_dir = 0;
      else if (nmode == 2) m_dir = 1;
      m_mode = nmode;
      for (int i = 0; i < 2; i++) begin
        if (m_age >= 2 && m_s2[i] == 1) m_arm[i] = 1;
        m_dbq[i] = m_db[i];
        if (m_s2[i] != m_db[i]) begin
          if (m_run_len[i] + 1 >= DB) begin
            m_db[i] = m_s2[i];
            m_run_len[i] = 0;
          end else begin
            m_run_len[i]++;
          end
        end else begin
          m_run_len[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = pin[i];
      end
      if (m_age < 2) m_age++;
    end
  end

  // Compare DUT outputs with the model shortly after every edge.
  always @(posedge clk) begin
    #1;
    if (m_ok) begin
      chk("cyc_led", int'(Led), m_led);
      chk("cyc_run", int'(run), (m_mode != 0) ? 1 : 0);
      chk("cyc_dir", int'(dir), m_dir);
      chk("cyc_tick", int'(tick), (m_mode != 0 && m_phase == TD - 1) ? 1 : 0);
    end
  end

  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input bit a, input bit b, input int n);
    @(negedge clk);
    p1 = a;
    p2 = b;
    repeat (n) @(negedge clk);
    p1 = 1'b1;
    p2 = 1'b1;
  endtask

  initial begin
    int budget;
    // Reset hold with buttons released.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_led", int'(Led), 3);
      chk("rst_run", int'(run), 0);
      chk("rst_dir", int'(dir), 0);
      chk("rst_tick", int'(tick), 0);
    end

    // p1 held low 10 cycles; next edge is E0.
    @(negedge clk);
    p1 = 1'b0;
    edge_n(5);                      // E4
    chk("fwd_run_e4", int'(run), 0);
    edge_n(1);                      // E5
    chk("fwd_run_e5", int'(run), 1);
    chk("fwd_dir_e5", int'(dir), 0);
    chk("fwd_led_e5", int'(Led), 3);
    edge_n(3);                      // E8
    chk("fwd_tick_e8", int'(tick), 1);
    edge_n(1);                      // E9
    chk("fwd_led_e9", int'(Led), 2);
    chk("fwd_tick_e9", int'(tick), 0);
    p1 = 1'b1;
    edge_n(4);                      // E13
    chk("fwd_led_e13", int'(Led), 1);
    edge_n(4);                      // E17
    chk("fwd_led_e17", int'(Led), 0);
    edge_n(4);                      // E21
    chk("fwd_led_e21", int'(Led), 3);

    // Reverse from Led=01, then pause with a second p2 press.
    edge_n(3);                      // E24
    p2 = 1'b0;                      // sampled first at E25
    edge_n(5);                      // E29
    chk("rev_led_pre", int'(Led), 1);
    chk("rev_dir_pre", int'(dir), 0);
    edge_n(1);                      // E30
    chk("rev_run", int'(run), 1);
    chk("rev_dir", int'(dir), 1);
    chk("rev_led_held", int'(Led), 1);
    p2 = 1'b1;
    edge_n(4);                      // E34
    chk("rev_led_step", int'(Led), 2);
    edge_n(6);                      // E40
    p2 = 1'b0;                      // sampled first at E41
    edge_n(5);                      // E45
    chk("pause_tick_pre", int'(tick), 1);
    chk("pause_led_pre", int'(Led), 0);
    edge_n(1);                      // E46: pause wins over the tick
    chk("pause_run", int'(run), 0);
    chk("pause_led", int'(Led), 0);
    chk("pause_dir", int'(dir), 1);
    p2 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      edge_n(1);
      chk("pause_tick", int'(tick), 0);
    end
    chk("pause_led_end", int'(Led), 0);

    // p1 bounce gives no event; a clean press then starts forward.
    @(negedge clk); p1 = 1'b0;
    repeat (2) @(negedge clk); p1 = 1'b1;
    @(negedge clk); p1 = 1'b0;
    repeat (2) @(negedge clk); p1 = 1'b1;
    repeat (12) @(negedge clk);
    chk("bounce_run", int'(run), 0);
    hold(1'b0, 1'b1, 6);
    repeat (12) @(negedge clk);
    chk("clean_run", int'(run), 1);
    chk("clean_dir", int'(dir), 0);

    // Go reverse, then both buttons together pause.
    hold(1'b1, 1'b0, 6);
    repeat (12) @(negedge clk);
    chk("both_pre_dir", int'(dir), 1);
    hold(1'b0, 1'b0, 6);
    repeat (12) @(negedge clk);
    chk("both_run", int'(run), 0);

    // Forward again, reset when the step count reaches 2 with buttons held.
    hold(1'b0, 1'b1, 6);
    budget = 200;
    while (!(m_mode == 1 && m_phase == 2) && budget > 0) begin
      edge_n(1);
      budget--;
    end
    chk("midrst_reach", (budget > 0) ? 1 : 0, 1);
    p1 = 1'b0;
    p2 = 1'b0;
    rst = 1'b0;
    edge_n(1);
    rst = 1'b1;
    chk("midrst_led", int'(Led), 3);
    chk("midrst_run", int'(run), 0);
    chk("midrst_dir", int'(dir), 0);
    chk("midrst_tick", int'(tick), 0);
    repeat (30) @(negedge clk);
    chk("held_no_event", int'(run), 0);
    p1 = 1'b1;
    p2 = 1'b1;
    repeat (12) @(negedge clk);
    hold(1'b0, 1'b1, 6);
    repeat (12) @(negedge clk);
    chk("repress_run", int'(run), 1);

    // Randomized button activity with occasional resets.
    for (int ep = 0; ep < 300; ep++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 7) hold(1'b0, 1'b1, $urandom_range(1, 8));
      else if (r < 13) hold(1'b1, 1'b0, $urandom_range(1, 8));
      else if (r < 16) hold(1'b0, 1'b0, $urandom_range(1, 8));
      else if (r < 19) repeat ($urandom_range(1, 20)) @(negedge clk);
      else begin
        @(negedge clk);
        rst = 1'b0;
        p1 = 1'($urandom_range(0, 1));
        p2 = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst = 1'b1;
        repeat ($urandom_range(0, 6)) @(negedge clk);
        p1 = 1'b1;
        p2 = 1'b1;
      end
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
